// File: rtl/multibank_buffer.sv
// multibank_buffer: single-clock N-bank circular frame buffer.
// The producer fills and commits whole banks; the consumer drains committed
// banks in order. Bank storage is one inferred RAM addressed as {bank, addr}.
// Optional build macro MULTIBANK_DROP_CNT_EN adds drop_cnt/ovf_flag, which
// count commits refused because every bank was already full.
module multibank_buffer #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 7,
  parameter int NUM_BANKS = 4,
  localparam int BANK_W   = $clog2(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_finish,
  input  logic [ADDR_W:0]   wr_len,
  output logic              wr_ready,
`ifdef MULTIBANK_DROP_CNT_EN
  output logic [15:0]       drop_cnt,
  output logic              ovf_flag,
`endif
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_finish,
  output logic              rd_ready,
  output logic [ADDR_W:0]   rd_len,
  output logic [BANK_W:0]   fill_cnt
);

  localparam int DEPTH = NUM_BANKS << ADDR_W;
  localparam logic [BANK_W:0] FULL_CNT = (BANK_W+1)'(NUM_BANKS);

  logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
  logic [BANK_W-1:0] rd_bank_q, rd_bank_d;
  logic [BANK_W:0]   fill_cnt_q, fill_cnt_d;
  logic [DATA_W-1:0] rd_data_q;
  logic [ADDR_W:0]   len_tbl_q [NUM_BANKS];
  logic [DATA_W-1:0] mem [DEPTH];

  logic wr_fire, commit, release_bank;

  // Handshake flags come straight from the registered bank count.
  assign wr_ready     = (fill_cnt_q != FULL_CNT);
  assign rd_ready     = (fill_cnt_q != '0);
  assign wr_fire      = wr_en && wr_ready;
  assign commit       = wr_finish && wr_ready;
  assign release_bank = rd_finish && rd_ready;

  // Pointer and occupancy next-state; a commit and a release together cancel.
  always_comb begin
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    fill_cnt_d = fill_cnt_q;
    if (commit)       wr_bank_d = wr_bank_q + BANK_W'(1);
    if (release_bank) rd_bank_d = rd_bank_q + BANK_W'(1);
    if (commit && !release_bank)      fill_cnt_d = fill_cnt_q + (BANK_W+1)'(1);
    else if (!commit && release_bank) fill_cnt_d = fill_cnt_q - (BANK_W+1)'(1);
  end

  // Pointer and occupancy registers; reset throws away every committed bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q  <= '0;
      rd_bank_q  <= '0;
      fill_cnt_q <= '0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  // Bank storage write port; a same-cycle commit still writes the old bank.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wr_bank_q, wr_addr}] <= wr_data;
  end

  // Per-bank length table, captured on commit and never cleared.
  always_ff @(posedge clk) begin
    if (commit) len_tbl_q[wr_bank_q] <= wr_len;
  end

  // Always-enabled registered read from the current read bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= mem[{rd_bank_q, rd_addr}];
  end

  assign rd_data  = rd_data_q;
  assign fill_cnt = fill_cnt_q;
  // The length table holds no reset, so report 0 while nothing is committed.
  assign rd_len   = rd_ready ? len_tbl_q[rd_bank_q] : '0;

`ifdef MULTIBANK_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        ovf_flag_q, ovf_flag_d;

  // Count refused commits (saturating) and remember that one ever happened.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    ovf_flag_d = ovf_flag_q;
    if (wr_finish && !wr_ready) begin
      ovf_flag_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Overflow statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
      ovf_flag_q <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      ovf_flag_q <= ovf_flag_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign ovf_flag = ovf_flag_q;
`endif

endmodule

// File: tb/tb_multibank_buffer.sv
// Bench for multibank_buffer: directed scenarios followed by random traffic,
// all checked against a bank-level reference model (arrays + modular counts).
module tb_multibank_buffer;
  localparam int DW = 8;
  localparam int AW = 7;
  localparam int NB = 4;
  localparam int BW = 2;
  localparam int WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, wr_finish, rd_finish;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   wr_len;
  logic          wr_ready, rd_ready;
  logic [DW-1:0] rd_data;
  logic [AW:0]   rd_len;
  logic [BW:0]   fill_cnt;
`ifdef MULTIBANK_DROP_CNT_EN
  logic [15:0]   drop_cnt;
  logic          ovf_flag;
`endif

  always #5 clk = ~clk;

  multibank_buffer #(.DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_finish(wr_finish), .wr_len(wr_len), .wr_ready(wr_ready),
`ifdef MULTIBANK_DROP_CNT_EN
    .drop_cnt(drop_cnt), .ovf_flag(ovf_flag),
`endif
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_finish(rd_finish),
    .rd_ready(rd_ready), .rd_len(rd_len), .fill_cnt(fill_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: which bank is being written/read, how many are queued,
  // what each bank holds, and which words have ever been written.
  int          m_wb, m_rb, m_cnt, m_drop;
  bit          m_ovf;
  logic [DW-1:0] m_mem [NB][WORDS];
  bit          m_vld [NB][WORDS];
  int          m_len [NB];
  bit          exp_rd_vld;
  logic [DW-1:0] exp_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wb = 0; m_rb = 0; m_cnt = 0; m_drop = 0; m_ovf = 0;
    exp_rd_vld = 0;
  endtask

  // Apply one clock edge worth of effect using the inputs currently driven.
  task automatic model_edge();
    bit wrdy, rrdy;
    wrdy = (m_cnt != NB);
    rrdy = (m_cnt != 0);
    exp_rd_vld = rrdy && m_vld[m_rb][rd_addr];
    exp_rd     = m_mem[m_rb][rd_addr];
    if (wr_en && wrdy) begin
      m_mem[m_wb][wr_addr] = wr_data;
      m_vld[m_wb][wr_addr] = 1'b1;
    end
    if (wr_finish && !wrdy) begin
      m_ovf = 1;
      if (m_drop < 65535) m_drop++;
    end
    if (wr_finish && wrdy) begin
      m_len[m_wb] = int'(wr_len);
      m_wb = (m_wb + 1) % NB;
      m_cnt++;
    end
    if (rd_finish && rrdy) begin
      m_rb = (m_rb + 1) % NB;
      m_cnt--;
    end
  endtask

  task automatic check_outs();
    chk("wr_ready", wr_ready, m_cnt != NB);
    chk("rd_ready", rd_ready, m_cnt != 0);
    chk("fill_cnt", fill_cnt, m_cnt);
    chk("rd_len",   rd_len,   m_cnt != 0 ? m_len[m_rb] : 0);
    if (exp_rd_vld) chk("rd_data", rd_data, exp_rd);
`ifdef MULTIBANK_DROP_CNT_EN
    chk("drop_cnt", drop_cnt, m_drop);
    chk("ovf_flag", ovf_flag, m_ovf);
`endif
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic clr_in();
    wr_en = 0; wr_finish = 0; rd_finish = 0;
  endtask

  initial begin
    for (int b = 0; b < NB; b++) begin
      m_len[b] = 0;
      for (int a = 0; a < WORDS; a++) begin
        m_mem[b][a] = '0;
        m_vld[b][a] = 1'b0;
      end
    end
    clr_in();
    wr_addr = '0; wr_data = '0; wr_len = '0; rd_addr = '0;
    rst_n = 1'b0;
    model_reset();

    // Reset then idle.
    #12;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_fill", fill_cnt, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_len", rd_len, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Full frame 0x00..0x7F, commit with length 128, read back address 5.
    for (int a = 0; a < WORDS; a++) begin
      wr_en = 1; wr_addr = AW'(a); wr_data = DW'(a);
      cycle();
    end
    wr_en = 0; wr_finish = 1; wr_len = 8'd128;
    cycle();
    clr_in();
    chk("t2_fill", fill_cnt, 1);
    chk("t2_rd_ready", rd_ready, 1);
    chk("t2_rd_len", rd_len, 128);
    rd_addr = 7'd5;
    cycle();
    chk("t2_rd5", rd_data, 8'h05);
    rd_finish = 1;
    cycle();
    clr_in();

    // Fill all four banks, then one refused commit.
    for (int i = 0; i < NB; i++) begin
      wr_en = 1; wr_addr = 7'd0; wr_data = DW'(10 * (i + 1));
      wr_finish = 1; wr_len = (AW+1)'(10 * (i + 1));
      cycle();
    end
    clr_in();
    chk("t3_fill", fill_cnt, 4);
    chk("t3_wr_ready", wr_ready, 0);
    wr_finish = 1; wr_len = 8'd99;
    cycle();
    clr_in();
    chk("t3_fill_ovf", fill_cnt, 4);
`ifdef MULTIBANK_DROP_CNT_EN
    chk("t3_drop", drop_cnt, 1);
    chk("t3_ovf", ovf_flag, 1);
`endif

    // Drain in commit order, then one refused release.
    rd_addr = 7'd0;
    for (int i = 0; i < NB; i++) begin
      chk("t4_len", rd_len, 10 * (i + 1));
      rd_finish = 1;
      cycle();
      chk("t4_first_word", rd_data, 10 * (i + 1));
    end
    clr_in();
    chk("t4_rd_ready", rd_ready, 0);
    rd_finish = 1;
    cycle();
    clr_in();
    chk("t4_fill_udf", fill_cnt, 0);

    // Two queued banks, then simultaneous commit+release across a wrap.
    for (int i = 0; i < 2; i++) begin
      wr_finish = 1; wr_len = 8'd50;
      cycle();
    end
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; wr_addr = 7'd9; wr_data = DW'(8'hC0 + i);
      wr_finish = 1; rd_finish = 1; wr_len = (AW+1)'(60 + i); rd_addr = 7'd9;
      cycle();
      chk("t5_fill", fill_cnt, 2);
    end
    clr_in();

    // Async reset mid-write with three banks queued.
    wr_finish = 1; wr_len = 8'd33;
    cycle();
    clr_in();
    chk("t6_fill3", fill_cnt, 3);
    wr_en = 1; wr_addr = 7'd3; wr_data = 8'h11;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_fill", fill_cnt, 0);
    chk("t6_rst_wr_ready", wr_ready, 1);
    chk("t6_rst_rd_ready", rd_ready, 0);
    chk("t6_rst_rd_data", rd_data, 0);
    clr_in();
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1; wr_addr = 7'd3; wr_data = 8'hA5; wr_finish = 1; wr_len = 8'd7;
    cycle();
    clr_in();
    rd_addr = 7'd3;
    cycle();
    chk("t6_bank0_data", rd_data, 8'hA5);
    chk("t6_bank0_len", rd_len, 7);

    // Random traffic, alternating producer-heavy and consumer-heavy phases.
    for (int n = 0; n < 3000; n++) begin
      bit prod_heavy;
      prod_heavy = ((n / 150) % 2) == 0;
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_addr   = AW'($urandom);
      wr_data   = DW'($urandom);
      wr_finish = ($urandom_range(0, 99) < (prod_heavy ? 20 : 6));
      wr_len    = (AW+1)'($urandom);
      rd_finish = ($urandom_range(0, 99) < (prod_heavy ? 6 : 20));
      rd_addr   = AW'($urandom);
      cycle();
    end
    clr_in();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multibank_buffer.md
Name: multibank_buffer

Overview:
Single-clock, N-bank circular frame buffer. It generalises the two-sector ping-pong scheme to NUM_BANKS banks, with a per-bank frame length and explicit full/empty tracking. A producer (ADC capture, FFT output) fills whole banks and commits each one. A consumer (UART/SPI sender, display) drains committed banks in order. Storage is inferred RAM; no vendor IP.

Parameters:
DATA_W, 8, data word width
ADDR_W, 7, in-bank address width; each bank holds 2^ADDR_W words
NUM_BANKS, 4, bank count; power of two, at least 2; BANK_W = clog2(NUM_BANKS)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  in-bank write address
wr_data  in  DATA_W  write data
wr_finish  in  1  commit current write bank (1-cycle pulse)
wr_len  in  ADDR_W+1  word count of bank being committed, sampled with wr_finish
wr_ready  out  1  a free bank is available to the producer
rd_addr  in  ADDR_W  in-bank read address
rd_data  out  DATA_W  read data, 1-cycle latency
rd_finish  in  1  release current read bank (1-cycle pulse)
rd_ready  out  1  a committed bank is available to the consumer
rd_len  out  ADDR_W+1  stored length of current read bank
fill_cnt  out  BANK_W+1  number of committed, unreleased banks (0..NUM_BANKS)

Behaviour:
- Registers: wr_bank, rd_bank (BANK_W, wrap mod NUM_BANKS), fill_cnt, len_tbl[NUM_BANKS].
- Physical RAM address = {bank, addr}; depth NUM_BANKS*2^ADDR_W.
- Reset (rst_n=0, async): wr_bank=0, rd_bank=0, fill_cnt=0, wr_ready=1, rd_ready=0, rd_len=0, rd_data=0. RAM contents and len_tbl are not cleared. Reset mid-frame discards all committed banks.
- wr_ready = (fill_cnt != NUM_BANKS); rd_ready = (fill_cnt != 0). Both derived from registered fill_cnt, so they update the cycle after the causing edge.
- Write: if wr_en && wr_ready, then RAM[{wr_bank,wr_addr}] <= wr_data. If wr_ready=0, wr_en is ignored.
- Commit: if wr_finish && wr_ready, then len_tbl[wr_bank] <= wr_len, wr_bank <= wr_bank+1, fill_cnt +1.
  - wr_en in the same cycle writes into the old bank before the switch.
  - wr_finish while wr_ready=0 is ignored (overflow).
- Release: if rd_finish && rd_ready, then rd_bank <= rd_bank+1, fill_cnt -1. rd_finish while rd_ready=0 is ignored (underflow).
- Simultaneous valid commit and release: both pointers advance; fill_cnt unchanged.
- wr_len above 2^ADDR_W is stored unchanged; the block does not interpret it.
- Read: rd_data <= RAM[{rd_bank,rd_addr}] every cycle (always enabled). rd_data reflects the rd_bank value at the sampling edge. After a release, the first valid word from the new bank appears 1 cycle after the switch edge.
- rd_len = len_tbl[rd_bank]; combinational from registers.
- Invariant: wr_bank = rd_bank + fill_cnt mod NUM_BANKS. The writer never writes a bank that is committed and unreleased, so there are no read/write collisions on valid data.

Optional Feature:
MULTIBANK_DROP_CNT_EN
- Defined: adds outputs drop_cnt (16 bits) and ovf_flag (1 bit).
  - drop_cnt increments, saturating at 0xFFFF, on each wr_finish while wr_ready=0.
  - ovf_flag is sticky; cleared only by reset.
  - Both reset to 0.
- Undefined: ports and logic absent; overflow commits are silently dropped.

Test Plan:
- Reset then idle (DATA_W=8, ADDR_W=7, NUM_BANKS=4) -> wr_ready=1, rd_ready=0, fill_cnt=0, rd_data=0.
- Write 0x00..0x7F to addr 0..127, wr_finish with wr_len=128 -> next cycle fill_cnt=1, rd_ready=1, rd_len=128; reading addr 5 gives 0x05 one cycle later.
- Commit 4 banks with lengths 10,20,30,40 and no reads -> wr_ready=0, fill_cnt=4. A 5th wr_finish is ignored: fill_cnt stays 4. With MULTIBANK_DROP_CNT_EN, drop_cnt=1 and ovf_flag=1.
- From fill_cnt=4, release 4 times -> rd_len sequence 10,20,30,40; then rd_ready=0. A further rd_finish is ignored and fill_cnt stays 0.
- fill_cnt=2, pulse wr_finish and rd_finish in the same cycle -> fill_cnt stays 2; both pointers advance by 1. Wrap after 4 commits puts wr_bank back at 0.
- Assert rst_n=0 asynchronously mid-write with fill_cnt=3 -> outputs return to reset values immediately; after release, the first commit lands in bank 0.
